// File: rtl/dscope_capture_mc_if.sv
// Record read-out stream: one channel sample per word, valid/ready handshake.
interface dscope_capture_mc_if #(
    parameter int SAMPLE_W = 8
);
    logic [SAMPLE_W-1:0] o_out_data;
    logic [3:0]          o_out_ch;
    logic                o_out_vld;
    logic                o_out_last;
    logic                i_out_rdy;

    modport master (
        output o_out_data, o_out_ch, o_out_vld, o_out_last,
        input  i_out_rdy
    );

    modport slave (
        input  o_out_data, o_out_ch, o_out_vld, o_out_last,
        output i_out_rdy
    );
endinterface

// File: rtl/dscope_capture_mc.sv
// Multi-channel scope capture: circular pre/post-trigger record with decimation,
// streamed out one channel word at a time after the record completes.
module dscope_capture_mc #(
    parameter int CH_COUNT = 4,
    parameter int SAMPLE_W = 8,
    parameter int DEPTH    = 256
) (
    input  logic                         sys_clk,
    input  logic                         rst,
    input  logic                         i_arm,
    input  logic [$clog2(DEPTH)-1:0]     i_pre_len,
    input  logic [7:0]                   i_decim,
    input  logic                         i_sync,
    input  logic                         i_smp_vld,
    input  logic [CH_COUNT*SAMPLE_W-1:0] i_smp_data,
    output logic                         o_busy,
    output logic                         o_done,
    dscope_capture_mc_if.master          out_if
);
    localparam int AW = $clog2(DEPTH);
    localparam int W  = CH_COUNT * SAMPLE_W;
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DUMP} state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, pre_q, pre_d, start_q, start_d;
    logic [7:0]     decim_q, decim_d, dcnt_q, dcnt_d;
    logic [AW:0]    cnt_q, cnt_d, rd_cnt_q, rd_cnt_d, post_len;
    logic           sync_q;
    logic           mem_vld_q, mem_vld_d, mem_last_q, mem_last_d;
    logic [W-1:0]   mem_q, cur_q, cur_d;
    logic [3:0]     ch_q, ch_d;
    logic           cur_vld_q, cur_vld_d, cur_last_q, cur_last_d, done_q, done_d;
    logic           capturing, accept, trig, hs, ch_end, out_last, consume, rd_en;
    logic [AW-1:0]  rd_addr;
    logic [SAMPLE_W-1:0] out_data;

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge sys_clk) begin
        if (accept)
            mem[wr_ptr_q] <= i_smp_data;
        if (rd_en)
            mem_q <= mem[rd_addr];
    end

    always_comb begin
        capturing = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
        accept    = capturing && i_smp_vld && (dcnt_q == 8'd0);
        trig      = i_sync && !sync_q;
        post_len  = DEPTH_W - {1'b0, pre_q};
        hs        = cur_vld_q && out_if.i_out_rdy;
        ch_end    = (ch_q == 4'(CH_COUNT-1));
        out_last  = cur_vld_q && cur_last_q && ch_end;
        // The read register refills in the same cycle it hands a sample to the
        // output stage, so single-channel records still stream without bubbles.
        consume   = mem_vld_q && (!cur_vld_q || (hs && ch_end));
        rd_en     = (state_q == S_DUMP) && (rd_cnt_q != DEPTH_W) && (!mem_vld_q || consume);
        rd_addr   = start_q + rd_cnt_q[AW-1:0];
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        pre_d      = pre_q;
        decim_d    = decim_q;
        dcnt_d     = dcnt_q;
        cnt_d      = cnt_q;
        start_d    = start_q;
        done_d     = 1'b0;
        rd_cnt_d   = rd_cnt_q;
        mem_vld_d  = mem_vld_q;
        mem_last_d = mem_last_q;
        cur_d      = cur_q;
        ch_d       = ch_q;
        cur_vld_d  = cur_vld_q;
        cur_last_d = cur_last_q;

        if (capturing && i_smp_vld)
            dcnt_d = (dcnt_q == 8'd0) ? decim_q : dcnt_q - 8'd1;
        if (accept)
            wr_ptr_d = wr_ptr_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (i_arm) begin
                    pre_d    = i_pre_len;
                    decim_d  = i_decim;
                    wr_ptr_d = '0;
                    dcnt_d   = 8'd0;
                    cnt_d    = '0;
                    state_d  = (i_pre_len == '0) ? S_WAIT : S_PRE;
                end
            end
            S_PRE: begin
                if (accept) begin
                    if (cnt_q + 1'b1 == {1'b0, pre_q}) begin
                        cnt_d   = '0;
                        state_d = S_WAIT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (trig) begin
                    start_d = wr_ptr_q - pre_q;
                    cnt_d   = accept ? (AW+1)'(1) : '0;
                    state_d = (accept && post_len == (AW+1)'(1)) ? S_DUMP : S_POST;
                end
            end
            S_POST: begin
                if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q + 1'b1 == post_len)
                        state_d = S_DUMP;
                end
            end
            S_DUMP: begin
                if (hs && out_last) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (consume)
            mem_vld_d = 1'b0;
        if (rd_en) begin
            mem_vld_d  = 1'b1;
            mem_last_d = (rd_cnt_q == DEPTH_W - 1'b1);
            rd_cnt_d   = rd_cnt_q + 1'b1;
        end
        if (hs) begin
            if (ch_end)
                cur_vld_d = 1'b0;
            else
                ch_d = ch_q + 4'd1;
        end
        if (consume) begin
            cur_d      = mem_q;
            cur_vld_d  = 1'b1;
            cur_last_d = mem_last_q;
            ch_d       = 4'd0;
        end
        if (state_d != S_DUMP) begin
            rd_cnt_d   = '0;
            mem_vld_d  = 1'b0;
            mem_last_d = 1'b0;
            cur_d      = '0;
            cur_vld_d  = 1'b0;
            cur_last_d = 1'b0;
            ch_d       = 4'd0;
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            pre_q      <= '0;
            decim_q    <= 8'd0;
            dcnt_q     <= 8'd0;
            cnt_q      <= '0;
            start_q    <= '0;
            sync_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_cnt_q   <= '0;
            mem_vld_q  <= 1'b0;
            mem_last_q <= 1'b0;
            cur_q      <= '0;
            ch_q       <= 4'd0;
            cur_vld_q  <= 1'b0;
            cur_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            pre_q      <= pre_d;
            decim_q    <= decim_d;
            dcnt_q     <= dcnt_d;
            cnt_q      <= cnt_d;
            start_q    <= start_d;
            sync_q     <= i_sync;
            done_q     <= done_d;
            rd_cnt_q   <= rd_cnt_d;
            mem_vld_q  <= mem_vld_d;
            mem_last_q <= mem_last_d;
            cur_q      <= cur_d;
            ch_q       <= ch_d;
            cur_vld_q  <= cur_vld_d;
            cur_last_q <= cur_last_d;
        end
    end

    always_comb begin
        out_data = '0;
        for (int k = 0; k < CH_COUNT; k++)
            if (ch_q == 4'(k))
                out_data = cur_q[k*SAMPLE_W +: SAMPLE_W];
    end

    assign out_if.o_out_data = out_data;
    assign out_if.o_out_ch   = ch_q;
    assign out_if.o_out_vld  = cur_vld_q;
    assign out_if.o_out_last = out_last;
    assign o_busy            = (state_q != S_IDLE);
    assign o_done            = done_q;
endmodule

// File: tb/tb_dscope_capture_mc.sv
// Randomized bench for dscope_capture_mc: queue-based record model feeds a scoreboard
// that a negedge monitor drains on every output handshake.
module tb_dscope_capture_mc;
    localparam int CH = 4, SW = 8, DEPTH = 16, AW = 4, W = CH * SW;

    typedef struct packed {
        logic [SW-1:0] data;
        logic [3:0]    ch;
        logic          last;
    } exp_t;

    logic          sys_clk = 1'b0;
    logic          rst = 1'b1;
    logic          i_arm = 1'b0, i_sync = 1'b0, i_smp_vld = 1'b0;
    logic [AW-1:0] i_pre_len = '0;
    logic [7:0]    i_decim = 8'd0;
    logic [W-1:0]  i_smp_data = '0;
    logic          o_busy, o_done;

    dscope_capture_mc_if #(.SAMPLE_W(SW)) out_if();

    dscope_capture_mc #(.CH_COUNT(CH), .SAMPLE_W(SW), .DEPTH(DEPTH)) dut (
        .sys_clk   (sys_clk),
        .rst       (rst),
        .i_arm     (i_arm),
        .i_pre_len (i_pre_len),
        .i_decim   (i_decim),
        .i_sync    (i_sync),
        .i_smp_vld (i_smp_vld),
        .i_smp_data(i_smp_data),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .out_if    (out_if)
    );

    always #5 sys_clk = ~sys_clk;

    int n_chk = 0, n_fail = 0, cyc = 0;
    always @(posedge sys_clk) cyc++;

    // Reference model state: every accepted sample since arm, in order.
    bit           m_active = 0, m_cap = 0;
    logic         m_prev = 1'b0;
    int           m_pre, m_decim, m_nval, m_trig, m_dump_cyc = 0;
    logic [W-1:0] m_acc[$];
    exp_t         exp_q[$];

    int            words = 0;
    logic [SW-1:0] got_q[$];
    bit            first_seen = 0, exp_done = 0, prev_stall = 0;
    exp_t          prev_w, mon_e;
    int            rdy_mode = 0, bp_cnt = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [W-1:0] ramp_word(input int n);
        logic [W-1:0] w;
        for (int k = 0; k < CH; k++) w[k*SW +: SW] = SW'(n + k);
        return w;
    endfunction

    task automatic model_cycle(input logic arm, input logic vld, input logic [W-1:0] d, input logic sync);
        bit edge_s;
        int base;
        edge_s = sync && !m_prev;
        m_prev = sync;
        if (!m_active) begin
            if (arm) begin
                m_active = 1; m_cap = 1;
                m_pre    = (int'(i_pre_len) > DEPTH-1) ? DEPTH-1 : int'(i_pre_len);
                m_decim  = int'(i_decim);
                m_nval   = 0; m_trig = -1;
                m_acc.delete();
            end
            return;
        end
        if (!m_cap) return;
        if (m_trig < 0 && edge_s && m_acc.size() >= m_pre) m_trig = m_acc.size();
        if (vld) begin
            if (m_nval % (m_decim + 1) == 0) m_acc.push_back(d);
            m_nval++;
        end
        if (m_trig >= 0 && m_acc.size() == m_trig - m_pre + DEPTH) begin
            m_cap = 0;
            m_dump_cyc = cyc;
            base = m_trig - m_pre;
            for (int s = 0; s < DEPTH; s++)
                for (int k = 0; k < CH; k++)
                    exp_q.push_back('{data: m_acc[base+s][k*SW +: SW], ch: 4'(k),
                                      last: (s == DEPTH-1 && k == CH-1)});
        end
    endtask

    task automatic drive_cycle(input logic arm, input logic vld, input logic [W-1:0] d, input logic sync);
        i_arm = arm; i_smp_vld = vld; i_smp_data = d; i_sync = sync;
        case (rdy_mode)
            0:       out_if.i_out_rdy = 1'b1;
            1:       out_if.i_out_rdy = 1'($urandom_range(0, 1));
            default: out_if.i_out_rdy = ((bp_cnt / 100) % 2) == 1;
        endcase
        if (m_active && !m_cap) bp_cnt++;
        model_cycle(arm, vld, d, sync);
        @(posedge sys_clk); #1;
    endtask

    always @(negedge sys_clk) begin
        if (rst) begin
            prev_stall = 0;
            exp_done   = 0;
        end else begin
            if (exp_done) begin
                check("done_pulse_busy", {o_done, o_busy}, 2'b10);
                exp_done = 0;
            end else begin
                check("done_idle", o_done, 0);
            end
            if (prev_stall)
                check("stall_hold", {out_if.o_out_vld, out_if.o_out_data, out_if.o_out_ch, out_if.o_out_last},
                      {1'b1, prev_w});
            if (out_if.o_out_vld && !first_seen) begin
                first_seen = 1;
                check("first_vld_latency", cyc - m_dump_cyc, 3);
            end
            if (out_if.o_out_vld && out_if.i_out_rdy) begin
                words++;
                got_q.push_back(out_if.o_out_data);
                check("word_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("word_data_ch_last", {out_if.o_out_data, out_if.o_out_ch, out_if.o_out_last}, mon_e);
                end
                if (out_if.o_out_last) exp_done = 1;
            end
            prev_stall = out_if.o_out_vld && !out_if.i_out_rdy;
            prev_w     = '{data: out_if.o_out_data, ch: out_if.o_out_ch, last: out_if.o_out_last};
        end
    end

    task automatic run_record(input int pre, input int decim, input bit ramp, input bit vrand,
                              input int t1, input int t2, input int rmode, input int rst_words,
                              input int xarm);
        int   nval = 0, sync_left = 0;
        bit   done_seen = 0, aborted = 0;
        logic vld, sync, arm;
        logic [W-1:0] d;
        got_q.delete(); words = 0; first_seen = 0; bp_cnt = 0; rdy_mode = rmode;
        i_pre_len = AW'(pre); i_decim = 8'(decim);
        drive_cycle(1'b1, 1'b0, '0, 1'b0);
        check("busy_after_arm", o_busy, 1);
        for (int c = 0; c < 4000 && !done_seen && !aborted; c++) begin
            vld = vrand ? ($urandom_range(0, 3) != 0) : 1'b1;
            d   = ramp ? ramp_word(nval) : W'($urandom);
            if (vld && (nval == t1 || nval == t2)) sync_left = 3;
            sync = (sync_left > 0);
            if (sync_left > 0) sync_left--;
            arm = (xarm >= 0) && vld && (nval == xarm);
            if (vld) nval++;
            drive_cycle(arm, vld, d, sync);
            if (o_done) done_seen = 1;
            if (rst_words >= 0 && words >= rst_words) begin
                rst = 1'b1; i_sync = 1'b0; i_smp_vld = 1'b0; i_arm = 1'b0;
                #1;
                check("async_rst_outputs", {out_if.o_out_vld, out_if.o_out_last, o_busy, o_done,
                      out_if.o_out_data, out_if.o_out_ch}, 0);
                exp_q.delete(); m_active = 0; m_cap = 0; m_prev = 1'b0;
                @(posedge sys_clk); #1;
                @(posedge sys_clk); #1;
                rst = 1'b0;
                aborted = 1;
            end
        end
        check("record_completes", done_seen || aborted, 1);
        m_active = 0;
        if (!aborted) begin
            check("record_word_count", words, DEPTH * CH);
            check("scoreboard_drained", exp_q.size(), 0);
        end
    endtask

    initial begin
        out_if.i_out_rdy = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1;
        check("reset_outputs", {out_if.o_out_vld, out_if.o_out_last, o_busy, o_done,
              out_if.o_out_data, out_if.o_out_ch}, 0);
        rst = 1'b0;
        @(posedge sys_clk); #1;

        // Basic ramp record, trigger at count 20.
        run_record(4, 0, 1, 0, 20, -1, 0, -1, -1);
        if (got_q.size() == DEPTH * CH) begin
            for (int k = 0; k < CH; k++) check("basic_sample0", got_q[k], 16 + k);
            check("basic_last_word", got_q[DEPTH*CH-1], 31 + 3);
        end
        // Decimation by 3, with a stray arm during PRE that must be ignored.
        run_record(4, 2, 1, 0, 30, -1, 0, -1, 5);
        if (got_q.size() == DEPTH * CH) begin
            check("decim_start", got_q[0], 18);
            check("decim_step", got_q[CH] - got_q[0], 3);
        end
        // Edge during PRE ignored, second edge triggers.
        run_record(8, 0, 1, 1, 3, 12, 1, -1, -1);
        if (got_q.size() == DEPTH * CH) check("pre_trig_start", got_q[0], 4);
        // Backpressure pattern with random data and gaps.
        run_record(4, 1, 0, 1, 40, -1, 2, -1, -1);
        // pre = 0: trigger-cycle sample is record index 0.
        run_record(0, 0, 1, 0, 10, -1, 0, -1, -1);
        if (got_q.size() == DEPTH * CH) check("pre0_start", got_q[0], 10);
        // pre = DEPTH-1: a single post-trigger sample.
        run_record(DEPTH-1, 0, 1, 0, 30, -1, 1, -1, -1);
        if (got_q.size() == DEPTH * CH) begin
            check("premax_start", got_q[0], 15);
            check("premax_last", got_q[DEPTH*CH-1], 30 + 3);
        end
        // Reset in the middle of DUMP, then a clean re-arm.
        run_record(5, 0, 0, 1, 25, -1, 0, 20, -1);
        run_record(4, 0, 1, 0, 20, -1, 0, -1, -1);
        if (got_q.size() == DEPTH * CH) check("rearm_sample0", got_q[0], 16);

        repeat (3) @(posedge sys_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
